// File: rtl/lbist_pkg.sv
// LBIST controller shared definitions: state encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lbist_pkg;

   // Default signature width and pattern count per run.
   localparam int unsigned LBIST_BITS_DEF     = 8;
   localparam int unsigned LBIST_PATTERNS_DEF = 255;

   // Controller states. Encoding is fixed so it reads the same in any dump.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_RUN     = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_COMPARE = 3'd4,
      ST_DONE    = 3'd5
   } lbist_state_e;

endpackage

// File: rtl/lbist_ctrl_comp.sv
// Equality comparator between the MISR signature and the golden value.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: A, B - operands (W bits); res - 1 when A equals B.
module comp #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         res
);

   assign res = (A == B);

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: seeds the TPG, runs PATTERNS cycles, settles, checks the MISR.
// Latency: start sampled at edge k gives done at edge k+PATTERNS+3.
// Backpressure: none; start is only accepted in IDLE/DONE, abort cancels any busy state.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, abort      - run request / run cancel (abort wins)
//   sig, golden       - MISR signature and its expected value (BITS wide)
//   tpg_load, tpg_en  - pattern generator seed / advance strobes
//   misr_clr, misr_en - MISR clear / compaction strobes
//   busy, done, pass  - run status; pass valid while done=1
//   count             - patterns applied in the current run
module lbist_ctrl
   import lbist_pkg::*;
#(
   parameter int unsigned BITS     = LBIST_BITS_DEF,
   parameter int unsigned PATTERNS = LBIST_PATTERNS_DEF,
   localparam int unsigned CW      = $clog2(PATTERNS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [BITS-1:0] sig,
   input  logic [BITS-1:0] golden,
   output logic            tpg_load,
   output logic            tpg_en,
   output logic            misr_clr,
   output logic            misr_en,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [CW-1:0]   count
);

   localparam logic [CW-1:0] PAT_LAST = CW'(PATTERNS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   lbist_state_e   state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic           pass_q, pass_d;
   logic           cmp_res;

   comp #(
      .W (BITS)
   ) u_comp (
      .A   (sig),
      .B   (golden),
      .res (cmp_res)
   );

   // A start is only honoured when abort is low; abort beats start everywhere.
   logic start_ok;
   assign start_ok = start & ~abort;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      pass_d   = pass_q;
      tpg_load = 1'b0;
      tpg_en   = 1'b0;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_INIT;
               count_d = '0;
               pass_d  = 1'b0;
            end
         end

         ST_INIT: begin
            busy     = 1'b1;
            tpg_load = 1'b1;
            misr_clr = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               count_d = '0;
               pass_d  = 1'b0;
            end else begin
               // The edge into RUN applies the first pattern, so the first
               // RUN cycle already reports count=1.
               state_d = ST_RUN;
               count_d = CNT_ONE;
            end
         end

         ST_RUN: begin
            busy    = 1'b1;
            tpg_en  = 1'b1;
            misr_en = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               count_d = '0;
               pass_d  = 1'b0;
            end else if (count_q >= PAT_LAST) begin
               // Last pattern is in flight; count holds (saturates) here.
               state_d = ST_SETTLE;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end

         ST_SETTLE: begin
            // Pattern generator frozen, MISR takes the final response.
            busy    = 1'b1;
            misr_en = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               count_d = '0;
               pass_d  = 1'b0;
            end else begin
               state_d = ST_COMPARE;
            end
         end

         ST_COMPARE: begin
            busy = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               count_d = '0;
               pass_d  = 1'b0;
            end else begin
               state_d = ST_DONE;
               pass_d  = cmp_res;
            end
         end

         ST_DONE: begin
            done = 1'b1;
            if (start_ok) begin
               state_d = ST_INIT;
               count_d = '0;
               pass_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pass_q  <= pass_d;
      end
   end

   assign pass  = pass_q;
   assign count = count_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Scoreboard bench for lbist_ctrl with BITS=8, PATTERNS=4.
// Stimulus pushes the expected per-cycle output vector and expected run results;
// a negedge monitor pops and compares them independently of the stimulus.
module tb_lbist_ctrl;

   localparam int E_IDLE = 0, E_INIT = 1, E_RUN = 2, E_SETTLE = 3, E_COMPARE = 4, E_DONE = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] sig = 8'h00;
   logic [7:0] golden = 8'hFC;
   logic       tpg_load, tpg_en, misr_clr, misr_en, busy, done, pass;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;
   int trace_idx = 0;
   logic done_prev = 1'b0;
   bit   stim_done = 1'b0;

   logic [9:0] exp_q[$];
   bit         res_q[$];

   lbist_ctrl #(
      .BITS     (8),
      .PATTERNS (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .sig      (sig),
      .golden   (golden),
      .tpg_load (tpg_load),
      .tpg_en   (tpg_en),
      .misr_clr (misr_clr),
      .misr_en  (misr_en),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .count    (count)
   );

   always #5 clk = ~clk;

   // {busy, done, pass, tpg_load, tpg_en, misr_clr, misr_en, count[2:0]}
   function automatic logic [9:0] vec(input int st, input bit p, input int c);
      logic [6:0] f;
      logic [2:0] cc;
      cc = 3'(c);
      case (st)
         E_INIT:    f = 7'b100_1010;
         E_RUN:     f = 7'b100_0101;
         E_SETTLE:  f = 7'b100_0001;
         E_COMPARE: f = 7'b100_0000;
         E_DONE:    f = {2'b01, p, 4'b0000};
         default:   f = 7'b000_0000;
      endcase
      return {f, cc};
   endfunction

   // Drive one cycle of inputs and record what the outputs must be after the edge.
   task automatic step(input bit s, input bit a, input bit r, input int st, input bit p, input int c);
      start = s;
      abort = a;
      rst   = r;
      exp_q.push_back(vec(st, p, c));
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
   endtask

   // kind: 0 plain run, 1 extra start in RUN, 2 abort at count=2, 3 reset in COMPARE
   task automatic run(input logic [7:0] s_val, input bit ep, input int kind);
      bit sj;
      sig = s_val;
      if (kind < 2) res_q.push_back(ep);
      step(1'b1, 1'b0, 1'b0, E_INIT, 1'b0, 0);
      for (int j = 1; j <= 7; j++) begin
         sj = (kind == 1) && (j == 3);
         if (kind == 2 && j == 3) begin
            step(1'b0, 1'b1, 1'b0, E_IDLE, 1'b0, 0);
            return;
         end
         if (kind == 3 && j == 7) begin
            step(1'b0, 1'b0, 1'b1, E_IDLE, 1'b0, 0);
            return;
         end
         if (j <= 4)       step(sj,   1'b0, 1'b0, E_RUN,     1'b0, j);
         else if (j == 5)  step(1'b0, 1'b0, 1'b0, E_SETTLE,  1'b0, 4);
         else if (j == 6)  step(1'b0, 1'b0, 1'b0, E_COMPARE, 1'b0, 4);
         else              step(1'b0, 1'b0, 1'b0, E_DONE,    ep,   4);
      end
   endtask

   // Monitor: per-cycle trace check plus a result check on every rising done.
   always @(negedge clk) begin
      logic [9:0] got, want;
      bit         rp;
      got = {busy, done, pass, tpg_load, tpg_en, misr_clr, misr_en, count};
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL trace[%0d] got=%b want=%b", trace_idx, got, want);
         end
         trace_idx++;
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
         total++;
         if (res_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected at trace[%0d] pass=%b", trace_idx, pass);
         end else begin
            rp = res_q.pop_front();
            if (pass !== rp) begin
               bad++;
               $display("FAIL run_pass got=%b want=%b", pass, rp);
            end
         end
      end
      done_prev <= done;
   end

   initial begin
      // Reset, and reset beating a simultaneous start.
      step(1'b0, 1'b0, 1'b1, E_IDLE, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, E_IDLE, 1'b0, 0);
      step(1'b1, 1'b0, 1'b1, E_IDLE, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 0);

      // Matching signature, then hold in DONE; abort in DONE does nothing.
      run(8'hFC, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, E_DONE, 1'b1, 4);
      step(1'b0, 1'b1, 0, E_DONE, 1'b1, 4);

      // Restart from DONE after a pass, then a mismatching signature.
      run(8'hFC, 1'b1, 0);
      run(8'hFF, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, E_DONE, 1'b0, 4);

      // Start pulsed mid-run is ignored.
      run(8'hFC, 1'b1, 1);

      // Abort at count=2, then abort+start together in IDLE.
      run(8'hFC, 1'b0, 2);
      step(1'b1, 1'b1, 1'b0, E_IDLE, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 0);
      run(8'hFC, 1'b1, 0);

      // Reset during COMPARE: outputs all zero and done must stay low.
      run(8'hFF, 1'b0, 3);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 0);
      run(8'hFF, 1'b0, 0);

      stim_done = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0 || res_q.size() != 0) begin
         bad++;
         $display("FAIL leftover trace=%0d results=%0d want 0/0", exp_q.size(), res_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout stim_done=%0d", stim_done);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lbist_ctrl.md
LBIST_CTRL -- requirements
Module: lbist_ctrl

Interface
REQ-001 Parameter BITS, default 8, sets the signature and golden-value width.
REQ-002 Parameter PATTERNS, default 255, sets the number of test patterns per run; PATTERNS SHALL be >= 1.
REQ-003 Port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 Port start, input, 1, requests a BIST run; sampled only in IDLE and DONE.
REQ-006 Port abort, input, 1, cancels a run in progress.
REQ-007 Port sig, input, BITS, MISR signature to be checked.
REQ-008 Port golden, input, BITS, expected signature; held stable by the system.
REQ-009 Port tpg_load, output, 1, seeds the pattern-generator LFSR.
REQ-010 Port tpg_en, output, 1, advances the pattern generator.
REQ-011 Port misr_clr, output, 1, clears the MISR.
REQ-012 Port misr_en, output, 1, lets the MISR compact responses.
REQ-013 Port busy, output, 1, high in INIT, RUN, SETTLE and COMPARE.
REQ-014 Port done, output, 1, high in DONE only.
REQ-015 Port pass, output, 1, registered comparison result; meaningful while done=1.
REQ-016 Port count, output, $clog2(PATTERNS+1), number of patterns applied in the current run.

Function
REQ-017 The FSM SHALL have the states IDLE, INIT, RUN, SETTLE, COMPARE and DONE; all strobes are Moore-decoded from the registered state.
REQ-018 IDLE with start=1 and abort=0 SHALL go to INIT; otherwise the FSM stays in IDLE.
REQ-019 INIT SHALL last 1 cycle with tpg_load=1, misr_clr=1 and count cleared to 0, then go to RUN.
REQ-020 RUN SHALL hold tpg_en=1 and misr_en=1 and increment count by 1 per cycle.
REQ-021 RUN SHALL go to SETTLE in the cycle where count reaches PATTERNS, giving exactly PATTERNS RUN cycles.
REQ-022 SETTLE SHALL last 1 cycle with misr_en=1 and tpg_en=0, capturing the final response.
REQ-023 COMPARE SHALL last 1 cycle and register pass <= comparator result (1 when sig==golden), then go to DONE.
REQ-024 DONE SHALL hold done=1, pass and count until a start is accepted.
REQ-025 start=1 in DONE SHALL go to INIT and clear pass to 0 in the same edge.
REQ-026 Latency: with start sampled at edge k, done SHALL rise at edge k+PATTERNS+3.
REQ-027 start in INIT, RUN, SETTLE or COMPARE SHALL be ignored.
REQ-028 abort=1 in any busy state SHALL go to IDLE at the next edge with pass=0 and count=0.
REQ-029 abort SHALL win over start when both are high in the same cycle.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 The count register SHALL never wrap; it saturates at PATTERNS.

Reset
REQ-032 rst=1 SHALL, at the next edge and from any state, force state=IDLE, count=0 and pass=0, with every output 0.
REQ-033 rst SHALL take priority over start and abort.

Structure
REQ-034 Package lbist_pkg SHALL hold the state encoding constants and the default BITS and PATTERNS values.
REQ-035 The existing comparator comp SHALL be instantiated once as the sole sub-module, with A=sig, B=golden and res feeding the pass register.
REQ-036 The block SHALL contain no other combinational compare logic.

Verification (BITS=8, PATTERNS=4)
REQ-037 Reset, then start pulse with golden='hFC and sig='hFC: INIT 1 cycle; RUN 4 cycles with count 1..4; done=1 and pass=1 at edge k+7.
REQ-038 Same run with sig='hFF: done=1 and pass=0.
REQ-039 start pulsed during RUN: no restart; done still rises at edge k+7.
REQ-040 abort at count=2: next cycle is IDLE with busy=0, tpg_en=0, misr_en=0 and count=0; abort together with start in IDLE stays in IDLE.
REQ-041 rst asserted in COMPARE: next cycle has all outputs 0 and done never rises.
REQ-042 start in DONE after a pass: pass drops to 0, INIT follows, and the run repeats with the same timing.
